ulbf_coeffs_streamer: RTL and testbench

Read-side sequencer for the 64-bit coefficient BRAM of the uplink beamformer. On a start command it walks a configured window of the coefficient memory through the BRAM's second port, repeats the window a configured number of times, and delivers the words as a 64-bit AXI4-Stream toward the AI Engine. Host writes continue independently on port A. Run/abort control and status come from the CSR space of the coefficient controller.

---
 rtl/ulbf_coeffs_streamer.sv | 208 ++++++++++++++++++++
 tb/tb_ulbf_coeffs_streamer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ulbf_coeffs_streamer.sv
// ulbf_coeffs_streamer: walks a window of the 64-bit coefficient BRAM through port B,
// repeats it a configured number of times and streams the words out as AXI4-Stream.
module ulbf_coeffs_streamer #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [15:0]       cfg_len,
    input  logic [15:0]       cfg_reps,
    output logic [31:0]       status,
    output logic              enb,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] doutb,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic              busy;
    logic              done;
    logic              err;
    logic              aborted;
    logic [15:0]       blk_cnt;
    logic [ADDR_W-1:0] base_q;
    logic [15:0]       len_q;
    logic [15:0]       reps_q;
    logic [15:0]       idx_q;
    logic [15:0]       rep_q;
    logic              enb_tag;

    logic [RD_LAT-1:0]     pipe_vld;
    logic [RD_LAT-1:0]     pipe_tag;
    logic [DATA_W-1:0]     fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic [CNT_W-1:0]      fifo_cnt;

    logic [ADDR_W-1:0] cur_base;
    logic [15:0]       cur_len;
    logic [15:0]       cur_reps;
    logic [15:0]       cur_idx;
    logic [15:0]       cur_rep;
    logic              start_ok;
    logic              blk_end;
    logic              run_end;
    logic              credit_ok;
    logic              issue;
    logic              pop;
    logic              push;
    logic              drain_done;
    logic [OCC_W-1:0]  occ_after;
    logic [CNT_W-1:0]  cnt_next;
    logic [CNT_W-1:0]  wr_ptr;

    assign status       = {blk_cnt, 12'd0, aborted, err, done, busy};
    assign m_axis_tdata = fifo_data[0];
    assign m_axis_tlast = fifo_last[0];

    // Read-issue decision: in IDLE the first read uses the live config, in RUN the latched one.
    always_comb begin
        cur_base = base_q;
        cur_len  = len_q;
        cur_reps = reps_q;
        cur_idx  = idx_q;
        cur_rep  = rep_q;
        if (state == ST_IDLE) begin
            cur_base = cfg_base;
            cur_len  = cfg_len;
            cur_reps = cfg_reps;
            cur_idx  = 16'd0;
            cur_rep  = 16'd0;
        end
        start_ok = start && (cfg_len != 16'd0) && (cfg_reps != 16'd0);
        blk_end  = (cur_idx == cur_len - 16'd1);
        run_end  = blk_end && (cur_rep == cur_reps - 16'd1);
        pop      = m_axis_tvalid && m_axis_tready;
        push     = pipe_vld[RD_LAT-1];
        // slots held after this edge: current read, pipe contents, FIFO minus the beat leaving now
        occ_after = OCC_W'(enb) + OCC_W'(fifo_cnt) - OCC_W'(pop);
        for (int i = 0; i < RD_LAT; i++) begin
            occ_after = occ_after + OCC_W'(pipe_vld[i]);
        end
        credit_ok  = occ_after < OCC_W'(FIFO_DEPTH);
        issue      = ((state == ST_IDLE) && start_ok) ||
                     ((state == ST_RUN) && !stop && credit_ok);
        wr_ptr     = fifo_cnt - CNT_W'(pop);
        cnt_next   = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        drain_done = !enb && (pipe_vld == '0) && (cnt_next == '0);
    end

    // Control FSM, window walker, BRAM port-B drive and status registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            aborted <= 1'b0;
            blk_cnt <= 16'd0;
            base_q  <= '0;
            len_q   <= 16'd0;
            reps_q  <= 16'd0;
            idx_q   <= 16'd0;
            rep_q   <= 16'd0;
            enb     <= 1'b0;
            addrb   <= '0;
            enb_tag <= 1'b0;
        end else begin
            enb <= 1'b0;
            if (issue) begin
                enb     <= 1'b1;
                addrb   <= cur_base + ADDR_W'(cur_idx);
                enb_tag <= blk_end;
                idx_q   <= blk_end ? 16'd0 : cur_idx + 16'd1;
                rep_q   <= blk_end ? cur_rep + 16'd1 : cur_rep;
            end
            if (pop && m_axis_tlast && (blk_cnt != 16'hFFFF)) begin
                blk_cnt <= blk_cnt + 16'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            state   <= run_end ? ST_DRAIN : ST_RUN;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                            err     <= 1'b0;
                            aborted <= 1'b0;
                            blk_cnt <= 16'd0;
                            base_q  <= cfg_base;
                            len_q   <= cfg_len;
                            reps_q  <= cfg_reps;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state   <= ST_DRAIN;
                        aborted <= 1'b1;
                    end else if (issue && run_end) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read-latency tag pipe and shift FIFO whose head entry drives the stream outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pipe_vld      <= '0;
            pipe_tag      <= '0;
            fifo_last     <= '0;
            fifo_cnt      <= '0;
            m_axis_tvalid <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= enb;
            pipe_tag[0] <= enb_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
            if (pop) begin
                for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                    fifo_data[i] <= fifo_data[i+1];
                    fifo_last[i] <= fifo_last[i+1];
                end
            end
            if (push) begin
                fifo_data[IDX_W'(wr_ptr)] <= doutb;
                fifo_last[IDX_W'(wr_ptr)] <= pipe_tag[RD_LAT-1];
            end
            fifo_cnt      <= cnt_next;
            m_axis_tvalid <= (cnt_next != '0);
        end
    end

endmodule

// File: tb/tb_ulbf_coeffs_streamer.sv
// Bench for ulbf_coeffs_streamer: table of run scenarios plus hand-written illegal/reset sequences.
module tb_ulbf_coeffs_streamer;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 64;
    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned FIFO_DEPTH = 4;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic              start;
    logic              stop;
    logic [ADDR_W-1:0] cfg_base;
    logic [15:0]       cfg_len;
    logic [15:0]       cfg_reps;
    logic [31:0]       status;
    logic              enb;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] doutb;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] base;
        logic [15:0] len;
        logic [15:0] reps;
        int          rdy_mode;        // 0: tready always high, 1: high one cycle in three
        int          stop_k;          // cycle carrying the stop pulse, -1 for none
        logic        stop_with_start;
        int          exp_beats;
        int          exp_lasts;
        logic [15:0] exp_blocks;
        logic        exp_aborted;
        int          exp_first_valid;
        logic [63:0] exp_last_data;
    } vec_t;

    vec_t vecs [6];
    vec_t rst_vec;

    ulbf_coeffs_streamer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop),
        .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_reps(cfg_reps), .status(status),
        .enb(enb), .addrb(addrb), .doutb(doutb),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
    );

    always #5 aclk = ~aclk;

    // BRAM port-B model: word n holds n, valid RD_LAT cycles after enb, poison otherwise
    logic [ADDR_W-1:0] rd_addr [RD_LAT];
    logic              rd_vld  [RD_LAT];
    always @(posedge aclk) begin
        rd_vld[0]  <= enb;
        rd_addr[0] <= addrb;
        for (int i = 1; i < RD_LAT; i++) begin
            rd_vld[i]  <= rd_vld[i-1];
            rd_addr[i] <= rd_addr[i-1];
        end
    end
    assign doutb = rd_vld[RD_LAT-1] ? 64'(rd_addr[RD_LAT-1]) : 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_enb"},    64'(enb), 64'd0);
        chk({tag, "_addrb"},  64'(addrb), 64'd0);
        chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        chk({tag, "_tlast"},  64'(m_axis_tlast), 64'd0);
        chk({tag, "_tdata"},  m_axis_tdata, 64'd0);
        chk({tag, "_status"}, 64'(status), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int          issued;
        int          accepted;
        int          lasts;
        int          first_v;
        int          last_acc;
        int          done_k;
        logic        prev_hold;
        logic [63:0] prev_data;
        logic        prev_last;
        logic [63:0] last_data;
        logic [15:0] e_addr;
        logic [15:0] e_idx;
        string       p;
        issued = 0; accepted = 0; lasts = 0; first_v = -1; last_acc = -1; done_k = -1;
        prev_hold = 1'b0; prev_data = '0; prev_last = 1'b0; last_data = '0;
        p = $sformatf("v%0d", id);
        @(negedge aclk);
        cfg_base = v.base; cfg_len = v.len; cfg_reps = v.reps;
        start = 1'b1; stop = v.stop_with_start; m_axis_tready = 1'b1;
        for (int k = 1; k < 3000; k++) begin
            @(negedge aclk);
            start = 1'b0;
            stop = (k == v.stop_k);
            m_axis_tready = (v.rdy_mode == 0) || (k % 3 == 0);
            if (k == 1) chk({p, "_busy_after_start"}, 64'(status[0]), 64'd1);
            if (status[1] && !status[0]) begin
                done_k = k;
                break;
            end
            if (v.stop_k > 0 && k > v.stop_k) chk({p, "_enb_after_stop"}, 64'(enb), 64'd0);
            if (enb) begin
                e_addr = v.base + 16'(issued % int'(v.len));
                chk($sformatf("%s_addrb%0d", p, issued), 64'(addrb), 64'(e_addr));
                issued++;
            end
            chk({p, "_outstanding_le_depth"}, 64'((issued - accepted) <= FIFO_DEPTH), 64'd1);
            if (prev_hold) begin
                chk({p, "_hold_tvalid"}, 64'(m_axis_tvalid), 64'd1);
                chk({p, "_hold_tdata"}, m_axis_tdata, prev_data);
                chk({p, "_hold_tlast"}, 64'(m_axis_tlast), 64'(prev_last));
            end
            if (m_axis_tvalid && first_v < 0) first_v = k;
            if (m_axis_tvalid && m_axis_tready) begin
                e_idx  = 16'(accepted % int'(v.len));
                e_addr = v.base + e_idx;
                chk($sformatf("%s_tdata%0d", p, accepted), m_axis_tdata, 64'(e_addr));
                chk($sformatf("%s_tlast%0d", p, accepted), 64'(m_axis_tlast),
                    64'(e_idx == v.len - 16'd1));
                if (m_axis_tlast) lasts++;
                accepted++;
                last_acc  = k;
                last_data = m_axis_tdata;
            end
            prev_hold = m_axis_tvalid && !m_axis_tready;
            prev_data = m_axis_tdata;
            prev_last = m_axis_tlast;
        end
        stop = 1'b0;
        chk({p, "_done_within_budget"}, 64'(done_k > 0), 64'd1);
        chk({p, "_done_after_last_beat"}, 64'(done_k), 64'(last_acc + 1));
        chk({p, "_beats"}, 64'(accepted), 64'(v.exp_beats));
        chk({p, "_reads"}, 64'(issued), 64'(v.exp_beats));
        chk({p, "_tlast_count"}, 64'(lasts), 64'(v.exp_lasts));
        chk({p, "_first_tvalid_cycle"}, 64'(first_v), 64'(v.exp_first_valid));
        chk({p, "_last_data"}, last_data, v.exp_last_data);
        chk({p, "_blocks"}, 64'(status[31:16]), 64'(v.exp_blocks));
        chk({p, "_aborted"}, 64'(status[3]), 64'(v.exp_aborted));
        chk({p, "_err"}, 64'(status[2]), 64'd0);
        chk({p, "_rsvd"}, 64'(status[15:4]), 64'd0);
        if (v.rdy_mode == 0) chk({p, "_no_bubbles"}, 64'(last_acc - first_v), 64'(v.exp_beats - 1));
    endtask

    task automatic illegal_start(input logic [15:0] len, input logic [15:0] reps, input string p);
        @(negedge aclk);
        cfg_base = 16'h0010; cfg_len = len; cfg_reps = reps; start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        chk({p, "_err_set"}, 64'(status[2]), 64'd1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_busy%0d", p, k), 64'(status[0]), 64'd0);
            chk($sformatf("%s_enb%0d", p, k), 64'(enb), 64'd0);
            @(negedge aclk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{base:16'h0010, len:16'd4, reps:16'd1, rdy_mode:0, stop_k:-1, stop_with_start:1'b0,
                    exp_beats:4, exp_lasts:1, exp_blocks:16'd1, exp_aborted:1'b0,
                    exp_first_valid:4, exp_last_data:64'h13};
        vecs[1] = '{base:16'hFFFE, len:16'd3, reps:16'd2, rdy_mode:0, stop_k:-1, stop_with_start:1'b0,
                    exp_beats:6, exp_lasts:2, exp_blocks:16'd2, exp_aborted:1'b0,
                    exp_first_valid:4, exp_last_data:64'h0};
        vecs[2] = '{base:16'h0100, len:16'd16, reps:16'd1, rdy_mode:1, stop_k:-1, stop_with_start:1'b0,
                    exp_beats:16, exp_lasts:1, exp_blocks:16'd1, exp_aborted:1'b0,
                    exp_first_valid:4, exp_last_data:64'h10F};
        vecs[3] = '{base:16'h0200, len:16'd100, reps:16'd1, rdy_mode:0, stop_k:10, stop_with_start:1'b0,
                    exp_beats:10, exp_lasts:0, exp_blocks:16'd0, exp_aborted:1'b1,
                    exp_first_valid:4, exp_last_data:64'h209};
        vecs[4] = '{base:16'h0300, len:16'd1, reps:16'd3, rdy_mode:0, stop_k:-1, stop_with_start:1'b1,
                    exp_beats:3, exp_lasts:3, exp_blocks:16'd3, exp_aborted:1'b0,
                    exp_first_valid:4, exp_last_data:64'h300};
        vecs[5] = '{base:16'h0400, len:16'd2, reps:16'd2, rdy_mode:1, stop_k:-1, stop_with_start:1'b0,
                    exp_beats:4, exp_lasts:2, exp_blocks:16'd2, exp_aborted:1'b0,
                    exp_first_valid:4, exp_last_data:64'h401};
        rst_vec = '{base:16'h0500, len:16'd8, reps:16'd1, rdy_mode:0, stop_k:-1, stop_with_start:1'b0,
                    exp_beats:8, exp_lasts:1, exp_blocks:16'd1, exp_aborted:1'b0,
                    exp_first_valid:4, exp_last_data:64'h507};

        aresetn = 1'b0; start = 1'b0; stop = 1'b0; m_axis_tready = 1'b1;
        cfg_base = '0; cfg_len = '0; cfg_reps = '0;
        repeat (3) @(negedge aclk);
        chk_outputs_zero("reset");
        aresetn = 1'b1;
        @(negedge aclk);

        illegal_start(16'd0, 16'd1, "illegal_len0");

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        illegal_start(16'd5, 16'd0, "illegal_reps0");

        // reset asserted while beat 5 (0x504) is on the bus
        @(negedge aclk);
        cfg_base = 16'h0500; cfg_len = 16'd8; cfg_reps = 16'd1; start = 1'b1; m_axis_tready = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        repeat (7) @(negedge aclk);
        chk("midrun_beat5_valid", 64'(m_axis_tvalid), 64'd1);
        chk("midrun_beat5_data", m_axis_tdata, 64'h504);
        #2 aresetn = 1'b0;
        #1 chk_outputs_zero("midrun_reset");
        @(negedge aclk);
        aresetn = 1'b1;
        run_vec(rst_vec, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
